// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux_n slice.
// Optional feature macro: STREAM_DEMUX_STATS_EN (per-channel delivery counters).
package stream_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  // Select width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_demux_n_sat_counter.sv
// Saturating up-counter used for the drop counter and the per-channel statistics.
// The clear input is synchronous and has priority over inc.
module sat_counter
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, return to zero on clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// 1-to-NUM_CH streaming demultiplexer with one registered output stage.
// Each beat carries its own destination index; beats with an index past the
// last channel are swallowed and counted in drop_cnt.
// Optional feature macro: STREAM_DEMUX_STATS_EN adds the ch_cnt port holding
// one saturating delivered-beat counter per channel.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] ch_cnt
`endif
);

  logic              full;
  logic [SEL_W-1:0]  hold_sel;
  logic [DATA_W-1:0] hold_data;

  logic sel_ready;
  logic sel_ok;
  logic out_fire;
  logic in_fire;
  logic drop_inc;

  // Ready of the channel currently addressed by the held beat; other channels are ignored.
  always_comb begin
    sel_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hold_sel == SEL_W'(k)) sel_ready = out_ready[k];
    end
  end

  // An incoming select is usable only if it names an existing channel.
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_ok = 1'b1;
    end
  end

  // One-hot valid decode from the registered stage only.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_valid[k] = full && (hold_sel == SEL_W'(k));
    end
  end

  assign out_fire = full && sel_ready;
  assign in_ready = !full || sel_ready;
  assign in_fire  = in_valid && in_ready;
  assign drop_inc = in_fire && !sel_ok;
  assign out_data = hold_data;
  assign busy     = full;

  // Output stage: reload on a good beat, empty on a departure with nothing to replace it.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      hold_sel  <= '0;
      hold_data <= '0;
    end else if (in_fire && sel_ok) begin
      full      <= 1'b1;
      hold_sel  <= in_sel;
      hold_data <= in_data;
    end else if (out_fire) begin
      full      <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

`ifdef STREAM_DEMUX_STATS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_stats
    sat_counter #(.WIDTH(CNT_W)) u_ch_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (out_fire && (hold_sel == SEL_W'(k))),
      .count (ch_cnt[k*CNT_W +: CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Self-checking bench for stream_demux_n: a 4-channel instance driven from a
// vector table plus hand-written reset/stats sequences, and two 3-channel
// instances for the out-of-range select and drop counter saturation.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [15:0] drop_cnt;
  logic       busy;

  logic       v3;
  logic [7:0] d3;
  logic [1:0] s3;
  logic [2:0] r3;
  logic       ir3_a, ir3_b;
  logic [2:0] ov3_a, ov3_b;
  logic [7:0] od3_a, od3_b;
  logic [15:0] drop3_a;
  logic [1:0] drop3_b;
  logic       busy3_a, busy3_b;

`ifdef STREAM_DEMUX_STATS_EN
  logic [63:0] ch_cnt;
  logic [47:0] ch_cnt3_a;
  logic [5:0]  ch_cnt3_b;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       vin;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] rdy;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  stream_demux_n #(.DATA_W(8), .NUM_CH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .ch_cnt    (ch_cnt)
`endif
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .CNT_W(16)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v3),
    .in_ready  (ir3_a),
    .in_data   (d3),
    .in_sel    (s3),
    .out_valid (ov3_a),
    .out_ready (r3),
    .out_data  (od3_a),
    .drop_cnt  (drop3_a),
    .busy      (busy3_a)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .ch_cnt    (ch_cnt3_a)
`endif
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .CNT_W(2)) dut3s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v3),
    .in_ready  (ir3_b),
    .in_data   (d3),
    .in_sel    (s3),
    .out_valid (ov3_b),
    .out_ready (r3),
    .out_data  (od3_b),
    .drop_cnt  (drop3_b),
    .busy      (busy3_b)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .ch_cnt    (ch_cnt3_b)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    in_valid  = v.vin;
    in_sel    = v.sel;
    in_data   = v.data;
    out_ready = v.rdy;
    #1;
  endtask

  task automatic addVec(input logic vin, input logic [1:0] sel, input logic [7:0] data,
                        input logic [3:0] rdy, input logic er, input logic [3:0] ev,
                        input logic [7:0] ed, input logic eb);
    vec_t v;
    v.vin = vin; v.sel = sel; v.data = data; v.rdy = rdy;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic idleInputs();
    in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'hF;
    v3 = 1'b0; s3 = 2'd0; d3 = 8'h00; r3 = 3'b111;
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;

    // Single beat to ch1.
    addVec(1, 2'd1, 8'h3C, 4'hF, 1, 4'b0000, 8'h00, 0);
    addVec(0, 2'd0, 8'h00, 4'hF, 1, 4'b0010, 8'h3C, 1);
    addVec(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 8'h3C, 0);
    // Streaming 0x10..0x17 across channels 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      if (i == 0)
        addVec(1, 2'(i % 4), 8'(8'h10 + i), 4'hF, 1, 4'b0000, 8'h3C, 0);
      else
        addVec(1, 2'(i % 4), 8'(8'h10 + i), 4'hF, 1, 4'(1 << ((i - 1) % 4)), 8'(8'h10 + i - 1), 1);
    end
    addVec(0, 2'd0, 8'h00, 4'hF, 1, 4'b1000, 8'h17, 1);
    addVec(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 8'h17, 0);
    // Backpressure on ch3 for five cycles, next beat waiting.
    addVec(1, 2'd3, 8'h55, 4'hF, 1, 4'b0000, 8'h17, 0);
    for (int i = 0; i < 5; i++)
      addVec(1, 2'd0, 8'h66, 4'b0111, 0, 4'b1000, 8'h55, 1);
    addVec(1, 2'd0, 8'h66, 4'hF, 1, 4'b1000, 8'h55, 1);
    addVec(0, 2'd0, 8'h00, 4'hF, 1, 4'b0001, 8'h66, 1);
    addVec(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 8'h66, 0);

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset in_ready", 64'(in_ready), 64'h1);
    checkOutput("reset out_data", 64'(out_data), 64'h0);
    checkOutput("reset drop_cnt", 64'(drop_cnt), 64'h0);

    $display("[TB] vector table, %0d rows", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end

    $display("[TB] reset while ch2 stalled");
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
    #1;
    checkOutput("stall accept in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("stall out_valid", 64'(out_valid), 64'b0100);
    checkOutput("stall out_data", 64'(out_data), 64'hA5);
    checkOutput("stall in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(out_valid), 64'h0);
    checkOutput("midreset busy", 64'(busy), 64'h0);
    checkOutput("midreset drop_cnt", 64'(drop_cnt), 64'h0);
    checkOutput("midreset in_ready", 64'(in_ready), 64'h1);
    checkOutput("midreset out_data", 64'(out_data), 64'h0);
    out_ready = 4'hF;

    $display("[TB] stats traffic: 5 beats ch0, 2 beats ch2");
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = (i < 5) ? 2'd0 : 2'd2;
      in_data  = 8'(8'h40 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("stats last beat out_valid", 64'(out_valid), 64'b0100);
    checkOutput("stats last beat out_data", 64'(out_data), 64'h46);
    @(negedge clk);
    #1;
`ifdef STREAM_DEMUX_STATS_EN
    checkOutput("ch_cnt[0]", 64'(ch_cnt[15:0]), 64'd5);
    checkOutput("ch_cnt[1]", 64'(ch_cnt[31:16]), 64'd0);
    checkOutput("ch_cnt[2]", 64'(ch_cnt[47:32]), 64'd2);
    checkOutput("ch_cnt[3]", 64'(ch_cnt[63:48]), 64'd0);
`endif
    checkOutput("stats drained busy", 64'(busy), 64'h0);

    $display("[TB] invalid select on 3-channel instances");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v3 = 1'b1; s3 = 2'd3; d3 = 8'(8'hE0 + i);
      #1;
      checkOutput($sformatf("inv%0d out_valid", i), 64'(ov3_a), 64'h0);
      checkOutput($sformatf("inv%0d in_ready", i), 64'(ir3_a), 64'h1);
      checkOutput($sformatf("inv%0d drop_cnt", i), 64'(drop3_a), 64'(i));
    end
    @(negedge clk);
    v3 = 1'b1; s3 = 2'd2; d3 = 8'h9A;
    #1;
    checkOutput("inv out_valid after drops", 64'(ov3_a), 64'h0);
    checkOutput("inv busy after drops", 64'(busy3_a), 64'h0);
    checkOutput("drop_cnt after 4", 64'(drop3_a), 64'd4);
    checkOutput("drop_cnt saturated", 64'(drop3_b), 64'd3);
    @(negedge clk);
    v3 = 1'b0;
    #1;
    checkOutput("ch2 beat out_valid", 64'(ov3_a), 64'b100);
    checkOutput("ch2 beat out_data", 64'(od3_a), 64'h9A);
    checkOutput("ch2 beat sat out_valid", 64'(ov3_b), 64'b100);
    checkOutput("drop_cnt stable", 64'(drop3_a), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised 1-to-NUM_CH streaming demultiplexer, successor to the combinational 1-to-2 demux.
- Routes one input stream to one of NUM_CH output channels, chosen per beat by a select field that travels with the data.
- Uses valid/ready handshakes on every port and a single registered output stage, so latency is 1 cycle and throughput is 1 beat/cycle.
- Counts beats with an out-of-range select. Used wherever one producer feeds several consumers.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- NUM_CH, 4, number of output channels (>=2; need not be a power of two).
- SEL_W, $clog2(NUM_CH), select width; derived, never overridden.
- CNT_W, 16, width of the drop counter and the statistics counters.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index.
- out_valid  out  NUM_CH  one valid bit per channel; at most one bit high.
- out_ready  in  NUM_CH  one ready bit per channel.
- out_data  out  DATA_W  payload, shared by all channels (broadcast).
- drop_cnt  out  CNT_W  count of beats dropped for an invalid select; saturating.
- busy  out  1  output stage is holding a beat.

Behaviour:
- Reset is synchronous: rst high at a clock edge applies it, whatever the handshake state.
  - Clears full, hold_sel, out_data, drop_cnt and all stats counters to 0.
  - An in-flight beat is discarded and is not counted.
  - During reset and in the first cycle after it: out_valid = 0 and busy = 0.
  - in_ready follows its normal rule: it is 1 when the stage is empty.
- Internal state:
  - full flag, mirrored on busy.
  - hold_sel (SEL_W bits).
  - hold_data, driven on out_data.
- Output decode:
  - out_valid[k] = full && (hold_sel == k).
  - out_data = hold_data for every channel, including channels whose valid is low.
- Departure: out_fire = full && out_ready[hold_sel]. Ready bits of non-selected channels are ignored.
- Accept rule: in_ready = !full || out_ready[hold_sel]. This gives back-to-back pass-through with no bubble.
- Input transfer: in_fire = in_valid && in_ready.
- in_fire with in_sel < NUM_CH:
  - At the next edge, hold_data <= in_data, hold_sel <= in_sel, full <= 1.
  - The beat is visible on out_valid[in_sel] in the cycle after acceptance (latency exactly 1).
- in_fire with in_sel >= NUM_CH (only possible when NUM_CH is not a power of two):
  - The beat is consumed and not stored.
  - drop_cnt increments, holding at 2^CNT_W-1.
  - full <= full && !out_fire, i.e. any pending departure still empties the stage.
- Simultaneous out_fire and valid in_fire: the stage reloads with the new beat and full stays 1.
- out_fire with no in_fire: full <= 0.
- Stall: while full && !out_ready[hold_sel], out_valid, out_data and hold_sel stay stable, and in_ready = 0.
- Destinations may change beat to beat with no dead cycle (e.g. ch0 then ch3).
- No combinational path from in_valid, in_data or in_sel to any output. in_ready depends combinationally on out_ready only.

Optional Feature:
- Macro: STREAM_DEMUX_STATS_EN.
- Defined:
  - Adds output port ch_cnt [NUM_CH*CNT_W], with slice k = beats delivered on channel k.
  - Slice k increments on each out_fire with hold_sel == k, saturates, and clears on rst.
- Undefined: the ch_cnt port and its counters do not exist. All other behaviour is identical.

Decomposition:
- Package stream_demux_pkg holds:
  - default constants DEF_DATA_W = 8, DEF_NUM_CH = 4, DEF_CNT_W = 16;
  - function sel_width(n), returning max(1, $clog2(n)).
- Sub-module sat_counter (WIDTH, inc, clear -> count), used by drop_cnt and by each stats counter.

Test Plan:
- Reset mid-operation: assert rst while ch2 is stalled holding 0xA5 -> next cycle out_valid = 0, busy = 0, drop_cnt = 0, in_ready = 1.
- Single beat: in_sel = 1, in_data = 0x3C, all out_ready = 1 -> out_valid = 4'b0010 and out_data = 0x3C exactly 1 cycle after acceptance; then out_valid = 0.
- Streaming: 8 consecutive beats with sel 0,1,2,3,0,1,2,3 and data 0x10..0x17, all ready -> in_ready stays 1 and each beat appears one cycle later on the correct channel with no gaps.
- Backpressure: beat 0x55 to ch3 with out_ready[3] = 0 for 5 cycles while out_ready[0..2] = 1 -> out_valid = 4'b1000 and out_data = 0x55 held; in_ready = 0; release -> next beat accepted in the same cycle.
- Invalid select (NUM_CH = 3, SEL_W = 2): drive in_sel = 3 for 4 beats -> no out_valid asserted, drop_cnt = 4. Separately with CNT_W = 2 -> drop_cnt saturates at 3.
- STREAM_DEMUX_STATS_EN defined: 5 beats to ch0 and 2 to ch2 -> ch_cnt slice 0 = 5, slice 2 = 2, others 0. Macro undefined -> the design compiles without the ch_cnt port.
